// File: rtl/ud_counter_cfg_seq_if.sv
// Bundle of host handshake, counter register bus and run/status signals
// shared between the configuration sequencer and its environment.
interface ud_counter_cfg_seq_if;
  // Host side
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_data;
  logic        abort;
  logic        busy;
  logic        done;
  logic [1:0]  status;

  // Counter register bus
  logic        a0;
  logic        a1;
  logic        ncs;
  logic        nwr;
  logic        nrd;
  logic [7:0]  dout;
  logic        dout_oe;
  logic [7:0]  din_rd;

  // Counter run control
  logic        start;
  logic        ec;
  logic        err;

  modport master (
    input  cfg_valid, cfg_data, abort, din_rd, ec, err,
    output cfg_ready, busy, done, status, a0, a1, ncs, nwr, nrd, dout, dout_oe, start
  );

  modport slave (
    output cfg_valid, cfg_data, abort, din_rd, ec, err,
    input  cfg_ready, busy, done, status, a0, a1, ncs, nwr, nrd, dout, dout_oe, start
  );
endinterface

// File: rtl/ud_counter_cfg_seq.sv
// Bus-master sequencer: writes a 4-byte config into the up/down counter, starts it and reports
// the outcome. Define READBACK_EN to verify each register by reading it back before start.
module ud_counter_cfg_seq #(
  parameter int unsigned STB_CYC = 2,
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned TO_W    = 16
) (
  input logic                  clk,
  input logic                  rst,
  ud_counter_cfg_seq_if.master bus
);

  typedef enum logic [3:0] {
    StIdle,
    StWrAddr,
    StWrStb,
    StWrHold,
    StWrGap,
    StRdAddr,
    StRdStb,
    StRdHold,
    StRdGap,
    StStart,
    StRun,
    StDone
  } state_e;

  localparam logic [1:0] StsOk       = 2'b00;
  localparam logic [1:0] StsErr      = 2'b01;
  localparam logic [1:0] StsTimeout  = 2'b10;
  localparam logic [1:0] StsMismatch = 2'b11;

  localparam logic [3:0]      StbLast = 4'(STB_CYC - 1);
  localparam logic [TO_W-1:0] ToLast  = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [31:0]     shadow_q, shadow_d;
  logic [3:0]      stb_cnt_q, stb_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [1:0]      status_q, status_d;
  logic [7:0]      cur_byte;

`ifdef READBACK_EN
  logic            mismatch_q, mismatch_d;
`endif

  assign cur_byte = shadow_q[{idx_q, 3'b000} +: 8];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    stb_cnt_d = stb_cnt_q;
    to_cnt_d  = to_cnt_q;
    status_d  = status_q;
`ifdef READBACK_EN
    mismatch_d = mismatch_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.cfg_valid) begin
          shadow_d = bus.cfg_data;
          idx_d    = 2'd0;
          state_d  = StWrAddr;
        end
      end

      StWrAddr: begin
        stb_cnt_d = 4'd0;
        state_d   = StWrStb;
      end

      StWrStb: begin
        if (stb_cnt_q == StbLast) begin
          stb_cnt_d = 4'd0;
          state_d   = StWrHold;
        end else begin
          stb_cnt_d = stb_cnt_q + 4'd1;
        end
      end

      StWrHold: state_d = StWrGap;

      StWrGap: begin
        if (idx_q == 2'd3) begin
          idx_d = 2'd0;
`ifdef READBACK_EN
          mismatch_d = 1'b0;
          state_d    = StRdAddr;
`else
          state_d    = StStart;
`endif
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = StWrAddr;
        end
      end

`ifdef READBACK_EN
      StRdAddr: begin
        stb_cnt_d = 4'd0;
        state_d   = StRdStb;
      end

      StRdStb: begin
        if (stb_cnt_q == StbLast) begin
          // Read data is taken on the final strobe clock, when it has had longest to settle.
          mismatch_d = (bus.din_rd != cur_byte);
          stb_cnt_d  = 4'd0;
          state_d    = StRdHold;
        end else begin
          stb_cnt_d = stb_cnt_q + 4'd1;
        end
      end

      StRdHold: state_d = StRdGap;

      StRdGap: begin
        if (mismatch_q) begin
          status_d = StsMismatch;
          state_d  = StDone;
        end else if (idx_q == 2'd3) begin
          state_d = StStart;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = StRdAddr;
        end
      end
`endif

      StStart: begin
        to_cnt_d = '0;
        state_d  = StRun;
      end

      StRun: begin
        // err wins over a simultaneous ec.
        if (bus.err) begin
          status_d = StsErr;
          state_d  = StDone;
        end else if (bus.ec) begin
          status_d = StsOk;
          state_d  = StDone;
        end else if ((TIMEOUT != 0) && (to_cnt_q == ToLast)) begin
          status_d = StsTimeout;
          state_d  = StDone;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase

    // Abort drops the bus immediately and leaves the last reported status intact.
    if (bus.abort && (state_q != StIdle)) begin
      state_d  = StIdle;
      status_d = status_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      idx_q      <= 2'd0;
      shadow_q   <= '0;
      stb_cnt_q  <= 4'd0;
      to_cnt_q   <= '0;
      status_q   <= StsOk;
`ifdef READBACK_EN
      mismatch_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      stb_cnt_q  <= stb_cnt_d;
      to_cnt_q   <= to_cnt_d;
      status_q   <= status_d;
`ifdef READBACK_EN
      mismatch_q <= mismatch_d;
`endif
    end
  end

  // Outputs decode purely from state so reset and abort take effect on the very next clock.
  always_comb begin
    bus.cfg_ready = 1'b0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    bus.status    = status_q;
    bus.ncs       = 1'b1;
    bus.nwr       = 1'b1;
    bus.nrd       = 1'b1;
    bus.a0        = 1'b0;
    bus.a1        = 1'b0;
    bus.dout      = 8'h00;
    bus.dout_oe   = 1'b0;
    bus.start     = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus.cfg_ready = 1'b1;
        bus.busy      = 1'b0;
      end

      StWrAddr, StWrHold: begin
        bus.ncs     = 1'b0;
        bus.a0      = idx_q[0];
        bus.a1      = idx_q[1];
        bus.dout    = cur_byte;
        bus.dout_oe = 1'b1;
      end

      StWrStb: begin
        bus.ncs     = 1'b0;
        bus.nwr     = 1'b0;
        bus.a0      = idx_q[0];
        bus.a1      = idx_q[1];
        bus.dout    = cur_byte;
        bus.dout_oe = 1'b1;
      end

`ifdef READBACK_EN
      StRdAddr, StRdHold: begin
        bus.ncs = 1'b0;
        bus.a0  = idx_q[0];
        bus.a1  = idx_q[1];
      end

      StRdStb: begin
        bus.ncs = 1'b0;
        bus.nrd = 1'b0;
        bus.a0  = idx_q[0];
        bus.a1  = idx_q[1];
      end
`endif

      StStart: bus.start = 1'b1;

      StDone: bus.done = 1'b1;

      default: ;
    endcase
  end

endmodule
